// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module  : keypad_pkg
// Brief   : Shared state type, key map and helpers for the keypad scanner.
// Revision: 1.0 - initial release
// ============================================================================
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    PRESSED  = 2'd2,
    REL_DB   = 2'd3
  } scan_state_t;

  // Indexed by {row, column}; row 3 carries '*' as E and '#' as F.
  localparam logic [15:0][3:0] c_keymap = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  localparam logic [3:0] c_col_reset = 4'b1110;

  function automatic logic [3:0] col_strobe(input logic [1:0] idx);
    col_strobe = ~(4'b0001 << idx);
  endfunction

  function automatic logic [1:0] lowest_low_row(input logic [3:0] rs);
    if (!rs[0]) begin
      lowest_low_row = 2'd0;
    end else if (!rs[1]) begin
      lowest_low_row = 2'd1;
    end else if (!rs[2]) begin
      lowest_low_row = 2'd2;
    end else begin
      lowest_low_row = 2'd3;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/scan_tick_gen.sv
`default_nettype none
// ============================================================================
// Module  : scan_tick_gen
// Brief   : Divides clk by SCAN_DIV into a one-cycle column-dwell tick.
// Revision: 1.0 - initial release
// ============================================================================
module scan_tick_gen #(
  parameter int SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] c_last = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_cnt == c_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module  : keypad_scanner
// Brief   : 4x4 matrix keypad scanner with debounce and valid/ack delivery.
// Revision: 1.0 - initial release
// ============================================================================
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_held,
  output logic       key_overrun
);

  localparam int DB_W = $clog2(DEBOUNCE + 1);
  localparam logic [DB_W-1:0] c_db_last = DB_W'(DEBOUNCE - 1);

  logic            w_tick;
  logic [3:0]      r_row_meta;
  logic [3:0]      r_rs;
  scan_state_t     r_state;
  logic [1:0]      r_col_idx;
  logic [1:0]      r_row_idx;
  logic [DB_W-1:0] r_db_cnt;
  logic [3:0]      r_col;
  logic [3:0]      r_key_code;
  logic            r_key_valid;
  logic            r_key_held;
  logic            r_key_overrun;

  logic            w_any_low;
  logic            w_row_up;
  logic [1:0]      w_col_next;

  scan_tick_gen #(
    .SCAN_DIV (SCAN_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick)
  );

  // Rows are raw pad inputs; only the second flop is ever looked at.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_meta <= 4'b1111;
      r_rs       <= 4'b1111;
    end else begin
      r_row_meta <= row;
      r_rs       <= r_row_meta;
    end
  end

  assign w_any_low  = ~&r_rs;
  assign w_row_up   = r_rs[r_row_idx];
  assign w_col_next = r_col_idx + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= SCAN;
      r_col_idx     <= '0;
      r_row_idx     <= '0;
      r_db_cnt      <= '0;
      r_col         <= c_col_reset;
      r_key_code    <= '0;
      r_key_valid   <= 1'b0;
      r_key_held    <= 1'b0;
      r_key_overrun <= 1'b0;
    end else begin
      r_key_overrun <= 1'b0;
      if (r_key_valid && key_ack) begin
        r_key_valid <= 1'b0;
      end
      // An accept below overrides the ack clear, so a coincident new key wins.
      if (w_tick) begin
        case (r_state)
          SCAN: begin
            if (w_any_low) begin
              r_row_idx <= lowest_low_row(r_rs);
              r_db_cnt  <= '0;
              r_state   <= PRESS_DB;
            end else begin
              r_col_idx <= w_col_next;
              r_col     <= col_strobe(w_col_next);
            end
          end
          PRESS_DB: begin
            if (!w_row_up) begin
              if (r_db_cnt == c_db_last) begin
                r_key_code    <= c_keymap[{r_row_idx, r_col_idx}];
                r_key_valid   <= 1'b1;
                r_key_overrun <= r_key_valid && !key_ack;
                r_key_held    <= 1'b1;
                r_state       <= PRESSED;
              end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
              end
            end else begin
              r_state   <= SCAN;
              r_col_idx <= w_col_next;
              r_col     <= col_strobe(w_col_next);
            end
          end
          PRESSED: begin
            if (w_row_up) begin
              r_db_cnt <= '0;
              r_state  <= REL_DB;
            end
          end
          REL_DB: begin
            if (w_row_up) begin
              if (r_db_cnt == c_db_last) begin
                r_key_held <= 1'b0;
                r_state    <= SCAN;
                r_col_idx  <= w_col_next;
                r_col      <= col_strobe(w_col_next);
              end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
              end
            end else begin
              r_state <= PRESSED;
            end
          end
          default: r_state <= SCAN;
        endcase
      end
    end
  end

  assign col         = r_col;
  assign key_code    = r_key_code;
  assign key_valid   = r_key_valid;
  assign key_held    = r_key_held;
  assign key_overrun = r_key_overrun;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module  : tb_keypad_scanner
// Brief   : Scoreboard bench for keypad_scanner with a modelled key matrix.
// Revision: 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 2;

  typedef struct packed {
    logic [3:0] code;
    logic       ovr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_ack;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic        key_overrun;

  logic [15:0] keys;
  int          m;
  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic        prev_valid;
  logic [3:0]  prev_code;
  logic [3:0]  exp_col;

  keypad_scanner #(
    .SCAN_DIV (SCAN_DIV),
    .DEBOUNCE (DEBOUNCE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .row         (row),
    .col         (col),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_ack     (key_ack),
    .key_held    (key_held),
    .key_overrun (key_overrun)
  );

  always #5 clk = ~clk;

  // Independent tick phase: m == SCAN_DIV-1 marks the deciding cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= 0;
    else        m <= (m == SCAN_DIV - 1) ? 0 : m + 1;
  end

  // Pressed key (r,c) pulls row r low only while column c is strobed.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_code  = 4'h0;
    end else begin
      if ((key_valid && (!prev_valid || key_code != prev_code)) || key_overrun) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_key: got code %0h overrun %0b, required no new key",
                   key_code, key_overrun);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_code", 32'(key_code), 32'(mon_e.code));
          chk("sb_overrun", 32'(key_overrun), 32'(mon_e.ovr));
        end
      end
      prev_valid = key_valid;
      prev_code  = key_code;
    end
  end

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do begin
        @(posedge clk);
        #1;
      end while (m != 0);
    end
  endtask

  task automatic wait_col(input int c);
    logic [3:0] want;
    int k;
    want = ~(4'b0001 << c);
    k = 0;
    do begin
      ticks(1);
      k++;
    end while (col != want && k < 8);
    chk("wait_col", 32'(col), 32'(want));
  endtask

  task automatic press(input int r, input int c);
    keys[r*4+c] = 1'b1;
  endtask

  task automatic unpress(input int r, input int c);
    keys[r*4+c] = 1'b0;
  endtask

  task automatic expect_key(input logic [3:0] code, input logic ovr);
    exp_t e;
    e.code = code;
    e.ovr  = ovr;
    exp_q.push_back(e);
  endtask

  task automatic ack_pulse();
    key_ack = 1'b1;
    @(posedge clk);
    #1;
    key_ack = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    key_ack = 1'b0;
    keys    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("rst_col", 32'(col), 32'hE);
    chk("rst_valid", 32'(key_valid), 0);
    chk("rst_held", 32'(key_held), 0);
    chk("rst_code", 32'(key_code), 0);
    chk("rst_overrun", 32'(key_overrun), 0);

    // Idle scan walks the columns once per tick.
    for (int i = 1; i <= 4; i++) begin
      ticks(1);
      exp_col = ~(4'b0001 << (i % 4));
      chk("idle_col", 32'(col), 32'(exp_col));
    end
    chk("idle_valid", 32'(key_valid), 0);

    // Single press of '6' (r1,c2), then release.
    wait_col(2);
    press(1, 2);
    expect_key(4'h6, 1'b0);
    ticks(3);
    chk("press_valid", 32'(key_valid), 1);
    chk("press_code", 32'(key_code), 6);
    chk("press_held", 32'(key_held), 1);
    chk("press_col", 32'(col), 32'b1011);
    unpress(1, 2);
    ticks(3);
    chk("release_held", 32'(key_held), 0);
    chk("resume_col", 32'(col), 32'b0111);
    ack_pulse();
    chk("ack_6", 32'(key_valid), 0);

    // One-tick bounce on row0 is rejected and scanning continues.
    wait_col(0);
    press(0, 0);
    ticks(1);
    unpress(0, 0);
    ticks(1);
    chk("bounce_valid", 32'(key_valid), 0);
    chk("bounce_col", 32'(col), 32'b1101);

    // 'A' with a one-tick release glitch, then handshake checks.
    wait_col(3);
    press(0, 3);
    expect_key(4'hA, 1'b0);
    ticks(3);
    chk("A_valid", 32'(key_valid), 1);
    chk("A_code", 32'(key_code), 32'hA);
    unpress(0, 3);
    ticks(1);
    press(0, 3);
    ticks(3);
    chk("glitch_held", 32'(key_held), 1);
    chk("glitch_valid", 32'(key_valid), 1);
    ack_pulse();
    chk("ack_A", 32'(key_valid), 0);
    ack_pulse();
    chk("idle_ack_valid", 32'(key_valid), 0);
    chk("idle_ack_held", 32'(key_held), 1);
    ticks(1);
    unpress(0, 3);
    ticks(3);
    chk("A_release_held", 32'(key_held), 0);
    chk("A_release_col", 32'(col), 32'b1110);

    // '1' left unacknowledged, then '0' overwrites it.
    press(0, 0);
    expect_key(4'h1, 1'b0);
    ticks(3);
    chk("one_valid", 32'(key_valid), 1);
    chk("one_code", 32'(key_code), 1);
    unpress(0, 0);
    ticks(3);
    chk("one_release_col", 32'(col), 32'b1101);
    press(3, 1);
    expect_key(4'h0, 1'b1);
    ticks(3);
    chk("ovr_code", 32'(key_code), 0);
    chk("ovr_valid", 32'(key_valid), 1);
    chk("ovr_pulse", 32'(key_overrun), 1);
    @(posedge clk);
    #1;
    chk("ovr_width", 32'(key_overrun), 0);
    ticks(1);
    unpress(3, 1);
    ticks(3);
    chk("zero_release_col", 32'(col), 32'b1011);

    // '9' accepted in the same cycle as an ack of the pending '0'.
    press(2, 2);
    expect_key(4'h9, 1'b0);
    ticks(2);
    do begin
      @(posedge clk);
      #1;
    end while (m != SCAN_DIV - 1);
    key_ack = 1'b1;
    @(posedge clk);
    #1;
    key_ack = 1'b0;
    chk("sim_valid", 32'(key_valid), 1);
    chk("sim_code", 32'(key_code), 9);
    chk("sim_overrun", 32'(key_overrun), 0);
    @(posedge clk);
    #1;
    chk("sim_valid_hold", 32'(key_valid), 1);
    ack_pulse();
    chk("sim_ack", 32'(key_valid), 0);
    ticks(1);
    unpress(2, 2);
    ticks(3);

    // Asynchronous reset in the middle of debouncing '5' (r1,c1).
    wait_col(1);
    press(1, 1);
    ticks(2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_col", 32'(col), 32'hE);
    chk("arst_valid", 32'(key_valid), 0);
    chk("arst_held", 32'(key_held), 0);
    chk("arst_code", 32'(key_code), 0);
    chk("arst_overrun", 32'(key_overrun), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    expect_key(4'h5, 1'b0);
    ticks(3);
    chk("arst_no_early", 32'(key_valid), 0);
    ticks(1);
    chk("arst_new_valid", 32'(key_valid), 1);
    chk("arst_new_code", 32'(key_code), 5);
    ack_pulse();
    ticks(1);
    unpress(1, 1);
    ticks(3);
    chk("final_held", 32'(key_held), 0);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
